// File: rtl/w_backward_combiner_if.sv
// B-channel packer link bundle: slave B beat in, packed beat out, error counter.
// The "slave" modport is the combiner's view; "master" is the surrounding logic.
interface w_backward_combiner_if #(
    parameter int ID_WIDTH   = 8,
    parameter int USER_WIDTH = 4,
    parameter int CNT_WIDTH  = 16
);
    localparam int DW = ID_WIDTH + 2 + USER_WIDTH;

    logic [ID_WIDTH-1:0]   BID;
    logic [1:0]            BRESP;
    logic [USER_WIDTH-1:0] BUSER;
    logic                  BVALID;
    logic                  BREADY;
    logic [DW-1:0]         DATA;
    logic                  VALID;
    logic                  READY;
    logic                  ERR_CLR;
    logic [CNT_WIDTH-1:0]  ERR_CNT;

    modport slave (
        input  BID, BRESP, BUSER, BVALID, READY, ERR_CLR,
        output BREADY, DATA, VALID, ERR_CNT
    );

    modport master (
        output BID, BRESP, BUSER, BVALID, READY, ERR_CLR,
        input  BREADY, DATA, VALID, ERR_CNT
    );
endinterface

// File: rtl/w_backward_combiner.sv
// AXI4 B-channel packer: registered 2-entry skid buffer from the slave B beat
// onto a packed DATA/VALID/READY link, plus a saturating error-response counter.
module w_backward_combiner #(
    parameter int ID_WIDTH   = 8,
    parameter int USER_WIDTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    w_backward_combiner_if.slave  bus
);
    localparam int DW = ID_WIDTH + 2 + USER_WIDTH;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [DW-1:0]        main_q, main_d;
    logic [DW-1:0]        skid_q, skid_d;
    logic                 bready_q, bready_d;
    logic                 valid_q, valid_d;
    logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

    logic [DW-1:0] beat;
    logic          s_xfer;
    logic          l_xfer;

    assign beat   = {bus.BID, bus.BRESP, bus.BUSER};
    assign s_xfer = bus.BVALID & bready_q;
    assign l_xfer = valid_q & bus.READY;

    // Skid-buffer next state; main always holds the oldest beat, skid the overflow.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (s_xfer) begin
                    main_d  = beat;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (s_xfer && l_xfer) begin
                    main_d = beat;
                end else if (s_xfer) begin
                    skid_d  = beat;
                    state_d = ST_FULL;
                end else if (l_xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (l_xfer) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Handshake outputs are flopped from the next state so neither side sees a comb path.
    always_comb begin
        bready_d = (state_d != ST_FULL);
        valid_d  = (state_d != ST_EMPTY);
    end

    // Error counter: clear wins over increment, increment stops at all-ones.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (bus.ERR_CLR) begin
            err_cnt_d = '0;
        end else if (s_xfer && bus.BRESP[1] && (err_cnt_q != {CNT_WIDTH{1'b1}})) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // State registers with asynchronous reset; reset drops any buffered beats.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= ST_EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            bready_q  <= 1'b0;
            valid_q   <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            main_q    <= main_d;
            skid_q    <= skid_d;
            bready_q  <= bready_d;
            valid_q   <= valid_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.BREADY  = bready_q;
    assign bus.VALID   = valid_q;
    assign bus.DATA    = main_q;
    assign bus.ERR_CNT = err_cnt_q;
endmodule

// File: tb/tb_w_backward_combiner.sv
// Directed bench for w_backward_combiner. A 4-bit error counter keeps the
// saturation case short; everything else uses the default widths.
module tb_w_backward_combiner;
    localparam int ID_W  = 8;
    localparam int USR_W = 4;
    localparam int CNT_W = 4;

    logic ACLK;
    logic ARESETn;
    int   checks;
    int   failures;

    w_backward_combiner_if #(
        .ID_WIDTH  (ID_W),
        .USER_WIDTH(USR_W),
        .CNT_WIDTH (CNT_W)
    ) bif ();

    w_backward_combiner #(
        .ID_WIDTH  (ID_W),
        .USER_WIDTH(USR_W),
        .CNT_WIDTH (CNT_W)
    ) dut (
        .ACLK   (ACLK),
        .ARESETn(ARESETn),
        .bus    (bif)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        checks++;
        if (obs !== expd) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expd);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic offer(input logic [7:0] id, input logic [1:0] r, input logic [3:0] u);
        bif.BID    = id;
        bif.BRESP  = r;
        bif.BUSER  = u;
        bif.BVALID = 1'b1;
    endtask

    function automatic logic [13:0] pack(input logic [7:0] id, input logic [1:0] r,
                                         input logic [3:0] u);
        return {id, r, u};
    endfunction

    initial begin
        checks     = 0;
        failures   = 0;
        bif.BID    = '0;
        bif.BRESP  = '0;
        bif.BUSER  = '0;
        bif.BVALID = 1'b0;
        bif.READY  = 1'b0;
        bif.ERR_CLR = 1'b0;
        ARESETn    = 1'b1;
        #1 ARESETn = 1'b0;

        // 1: reset values, BREADY rises on the first edge after release
        step();
        step();
        check_eq("rst_valid", 32'(bif.VALID), 32'd0);
        check_eq("rst_bready", 32'(bif.BREADY), 32'd0);
        check_eq("rst_data", 32'(bif.DATA), 32'd0);
        check_eq("rst_errcnt", 32'(bif.ERR_CNT), 32'd0);
        ARESETn = 1'b1;
        #1;
        check_eq("rel_bready_pre", 32'(bif.BREADY), 32'd0);
        step();
        check_eq("rel_bready_post", 32'(bif.BREADY), 32'd1);
        check_eq("rel_valid", 32'(bif.VALID), 32'd0);

        // 2: single pass-through; {8'hA5, 2'b01, 4'h3} packs to 14'h2953
        bif.READY = 1'b1;
        offer(8'hA5, 2'b01, 4'h3);
        step();
        bif.BVALID = 1'b0;
        check_eq("pt_valid", 32'(bif.VALID), 32'd1);
        check_eq("pt_data", 32'(bif.DATA), 32'h2953);
        step();
        check_eq("pt_valid_drop", 32'(bif.VALID), 32'd0);

        // 3: back-pressure fills both entries, then drains in order
        bif.READY = 1'b0;
        offer(8'h11, 2'b00, 4'h1);
        step();
        check_eq("bp_b1_bready", 32'(bif.BREADY), 32'd1);
        check_eq("bp_b1_data", 32'(bif.DATA), 32'(pack(8'h11, 2'b00, 4'h1)));
        offer(8'h22, 2'b01, 4'h2);
        step();
        check_eq("bp_full_bready", 32'(bif.BREADY), 32'd0);
        check_eq("bp_full_valid", 32'(bif.VALID), 32'd1);
        offer(8'h33, 2'b00, 4'h3);
        step();
        step();
        check_eq("bp_hold_data", 32'(bif.DATA), 32'(pack(8'h11, 2'b00, 4'h1)));
        check_eq("bp_hold_bready", 32'(bif.BREADY), 32'd0);
        bif.READY = 1'b1;
        step();
        check_eq("bp_d2_data", 32'(bif.DATA), 32'(pack(8'h22, 2'b01, 4'h2)));
        check_eq("bp_d2_bready", 32'(bif.BREADY), 32'd1);
        step();
        bif.BVALID = 1'b0;
        check_eq("bp_d3_data", 32'(bif.DATA), 32'(pack(8'h33, 2'b00, 4'h3)));
        check_eq("bp_d3_valid", 32'(bif.VALID), 32'd1);
        step();
        check_eq("bp_empty_valid", 32'(bif.VALID), 32'd0);
        check_eq("bp_errcnt", 32'(bif.ERR_CNT), 32'd0);

        // 4: 16 back-to-back beats at full rate
        for (int i = 0; i < 16; i++) begin
            offer(8'(i * 13 + 5), 2'(i % 2), 4'(15 - i));
            step();
            check_eq($sformatf("st_data%0d", i), 32'(bif.DATA),
                     32'(pack(8'(i * 13 + 5), 2'(i % 2), 4'(15 - i))));
            check_eq($sformatf("st_valid%0d", i), 32'(bif.VALID), 32'd1);
            check_eq($sformatf("st_bready%0d", i), 32'(bif.BREADY), 32'd1);
        end
        bif.BVALID = 1'b0;
        step();
        check_eq("st_end_valid", 32'(bif.VALID), 32'd0);

        // 5: error counting, clear priority, saturation
        begin
            logic [1:0] resps [6];
            resps = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b00, 2'b01};
            for (int i = 0; i < 6; i++) begin
                offer(8'(i), resps[i], 4'h0);
                step();
            end
        end
        bif.BVALID = 1'b0;
        check_eq("err_count4", 32'(bif.ERR_CNT), 32'd4);
        bif.ERR_CLR = 1'b1;
        offer(8'h40, 2'b10, 4'h0);
        step();
        bif.ERR_CLR = 1'b0;
        bif.BVALID  = 1'b0;
        check_eq("err_clr", 32'(bif.ERR_CNT), 32'd0);
        for (int i = 0; i < 20; i++) begin
            offer(8'(i), 2'b10, 4'h0);
            step();
            if (i == 13) check_eq("err_cnt14", 32'(bif.ERR_CNT), 32'd14);
        end
        bif.BVALID = 1'b0;
        check_eq("err_sat", 32'(bif.ERR_CNT), 32'd15);
        step();

        // 6: asynchronous reset while full discards both beats
        bif.READY = 1'b0;
        offer(8'h77, 2'b00, 4'h7);
        step();
        offer(8'h88, 2'b00, 4'h8);
        step();
        bif.BVALID = 1'b0;
        check_eq("rf_full_bready", 32'(bif.BREADY), 32'd0);
        #2 ARESETn = 1'b0;
        #1;
        check_eq("rf_async_valid", 32'(bif.VALID), 32'd0);
        check_eq("rf_async_data", 32'(bif.DATA), 32'd0);
        check_eq("rf_async_errcnt", 32'(bif.ERR_CNT), 32'd0);
        step();
        ARESETn = 1'b1;
        bif.READY = 1'b1;
        step();
        check_eq("rf_rel_bready", 32'(bif.BREADY), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("rf_nostale%0d", i), 32'(bif.VALID), 32'd0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
